// File: rtl/vol_sci_writer.sv
// Writes the volume word to the decoder's SCI_VOL register over SCI whenever it changes.
// Optional DREQ wait timeout is enabled by defining SCI_DREQ_TIMEOUT_EN.
module vol_sci_writer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [7:0]  SCI_ADDR    = 8'h0B,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [15:0] VOL,
    input  logic        FORCE,
    input  logic        DREQ,
    output logic        XCS,
    output logic        SCLK,
    output logic        SI,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DREQ,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [31:0] r_shift,       w_shift_nxt;
    logic [31:0] r_cnt,         w_cnt_nxt;
    logic [4:0]  r_bit,         w_bit_nxt;
    logic [15:0] r_vol_latched, w_vol_latched_nxt;
    logic [15:0] r_sent_vol,    w_sent_vol_nxt;
    logic        r_xcs,         w_xcs_nxt;
    logic        r_sclk,        w_sclk_nxt;
    logic        r_si,          w_si_nxt;
    logic        r_busy,        w_busy_nxt;
    logic        r_done,        w_done_nxt;
    logic        r_err,         w_err_nxt;

    logic        w_trigger;
    logic        w_div_end;
    logic        w_gap_end;

    // sent_vol resets to an illegal volume so the first enable always writes
    assign w_trigger = EN && ((VOL != r_sent_vol) || FORCE);
    assign w_div_end = (r_cnt == CLK_DIV - 1);
    assign w_gap_end = (r_cnt == GAP_CYC - 1);

`ifndef SCI_DREQ_TIMEOUT_EN
    logic w_timeout_unused;
    assign w_timeout_unused = ^TIMEOUT_CYC;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_cnt_nxt         = r_cnt + 32'd1;
        w_bit_nxt         = r_bit;
        w_vol_latched_nxt = r_vol_latched;
        w_sent_vol_nxt    = r_sent_vol;
        w_xcs_nxt         = r_xcs;
        w_sclk_nxt        = r_sclk;
        w_si_nxt          = r_si;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_err_nxt         = r_err;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_trigger) begin
                    w_shift_nxt       = {8'h02, SCI_ADDR, VOL};
                    w_vol_latched_nxt = VOL;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = S_WAIT_DREQ;
                end
            end
            S_WAIT_DREQ: begin
                if (DREQ) begin
                    w_xcs_nxt   = 1'b0;
                    w_si_nxt    = r_shift[31];
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end
`ifdef SCI_DREQ_TIMEOUT_EN
                // Adopting the live VOL as sent stops an immediate retry loop
                else if (r_cnt == TIMEOUT_CYC - 1) begin
                    w_err_nxt      = 1'b1;
                    w_sent_vol_nxt = VOL;
                    w_busy_nxt     = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_IDLE;
                end
`else
                else begin
                    w_cnt_nxt = '0;
                end
`endif
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_sclk_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_end) begin
                    w_sclk_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    if (r_bit == 5'd31) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_shift_nxt = {r_shift[30:0], 1'b0};
                        w_si_nxt    = r_shift[30];
                        w_bit_nxt   = r_bit + 5'd1;
                        w_state_nxt = S_SHIFT_LO;
                    end
                end
            end
            S_SHIFT_LO: begin
                if (w_div_end) begin
                    w_sclk_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_xcs_nxt      = 1'b1;
                    w_si_nxt       = 1'b0;
                    w_sent_vol_nxt = r_vol_latched;
                    w_done_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_vol_latched <= '0;
            r_sent_vol    <= 16'hFFFF;
            r_xcs         <= 1'b1;
            r_sclk        <= 1'b0;
            r_si          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit         <= w_bit_nxt;
            r_vol_latched <= w_vol_latched_nxt;
            r_sent_vol    <= w_sent_vol_nxt;
            r_xcs         <= w_xcs_nxt;
            r_sclk        <= w_sclk_nxt;
            r_si          <= w_si_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign XCS  = r_xcs;
    assign SCLK = r_sclk;
    assign SI   = r_si;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign ERR  = r_err;

endmodule

// File: tb/tb_vol_sci_writer.sv
// Bench for vol_sci_writer: an SCI slave monitor decodes frames and each scenario task
// compares them with frames predicted from the volume/trigger rules.
module tb_vol_sci_writer;

    localparam int unsigned DIV = 2;
    localparam int unsigned GAP = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic [15:0] VOL = 16'h0000;
    logic        FORCE = 1'b0;
    logic        DREQ = 1'b1;
    logic        XCS, SCLK, SI, BUSY, DONE, ERR;

    int errors = 0;
    int checks = 0;

    vol_sci_writer #(
        .CLK_DIV    (DIV),
        .SCI_ADDR   (8'h0B),
        .GAP_CYC    (GAP),
        .TIMEOUT_CYC(100)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .VOL  (VOL),
        .FORCE(FORCE),
        .DREQ (DREQ),
        .XCS  (XCS),
        .SCLK (SCLK),
        .SI   (SI),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR)
    );

    always #5 CLK = ~CLK;

    // SCI slave monitor
    logic [31:0] mon_sr = '0;
    int          mon_bits = 0;
    int          low_cnt = 0;
    int          hi_cnt = 0;
    int          min_gap = 1000;
    int          done_cnt = 0;
    int          sclk_rises = 0;
    logic [31:0] frames[$];
    int          bitsq[$];
    int          lowq[$];

    always @(posedge SCLK) begin
        sclk_rises++;
        if (!XCS) begin
            mon_sr = {mon_sr[30:0], SI};
            mon_bits++;
        end
    end

    always @(negedge XCS) begin
        mon_sr   = '0;
        mon_bits = 0;
        low_cnt  = 0;
        if (hi_cnt < min_gap) min_gap = hi_cnt;
    end

    always @(posedge XCS) begin
        if (RST_N) begin
            frames.push_back(mon_sr);
            bitsq.push_back(mon_bits);
            lowq.push_back(low_cnt);
        end
        hi_cnt = 0;
    end

    always @(negedge CLK) begin
        if (!XCS) low_cnt++;
        else      hi_cnt++;
        if (DONE) done_cnt++;
    end

    function automatic logic [31:0] exp_frame(input logic [15:0] v);
        return {8'h02, 8'h0B, v};
    endfunction

    function automatic logic [15:0] rand_vol();
        logic [7:0] l, r;
        l = 8'($urandom_range(0, 15) << 4);
        r = 8'($urandom_range(0, 15) << 4);
        return {l, r};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_force();
        FORCE = 1'b1;
        tick();
        FORCE = 1'b0;
    endtask

    task automatic clear_mon();
        frames.delete();
        bitsq.delete();
        lowq.delete();
    endtask

    // BUSY low for 20 consecutive cycles, bounded
    task automatic wait_quiet();
        int quiet = 0;
        for (int i = 0; i < 4000 && quiet < 20; i++) begin
            tick();
            if (!BUSY) quiet++;
            else       quiet = 0;
        end
        checks++;
        if (quiet < 20) begin
            errors++;
            $display("FAIL wait_quiet: BUSY did not settle low, got quiet=%0d required 20", quiet);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        checks++;
        if ({XCS, SCLK, SI, BUSY, DONE, ERR} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got XCS,SCLK,SI,BUSY,DONE,ERR=%b required 100000",
                     {XCS, SCLK, SI, BUSY, DONE, ERR});
        end
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_first_frame();
        clear_mon();
        done_cnt   = 0;
        sclk_rises = 0;
        EN   = 1'b0;
        VOL  = 16'h3030;
        DREQ = 1'b1;
        pulse_force();
        repeat (5) tick();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL en_gate: BUSY=%b required 0 while EN=0", BUSY);
        end
        EN = 1'b1;
        tick();
        checks++;
        if ({BUSY, XCS} !== 2'b11) begin
            errors++;
            $display("FAIL trig_busy: BUSY,XCS=%b required 11", {BUSY, XCS});
        end
        tick();
        checks++;
        if (XCS !== 1'b0) begin
            errors++;
            $display("FAIL trig_latency: XCS=%b required 0 two cycles after trigger", XCS);
        end
        wait_quiet();
        checks++;
        if (frames.size() !== 1) begin
            errors++;
            $display("FAIL first_count: frames=%0d required 1", frames.size());
        end else begin
            checks++;
            if (frames[0] !== exp_frame(16'h3030)) begin
                errors++;
                $display("FAIL first_data: got %h required %h", frames[0], exp_frame(16'h3030));
            end
            checks++;
            if (bitsq[0] !== 32 || lowq[0] !== 65 * DIV) begin
                errors++;
                $display("FAIL first_timing: bits=%0d low=%0d required 32 and %0d",
                         bitsq[0], lowq[0], 65 * DIV);
            end
        end
        checks++;
        if (done_cnt !== 1 || sclk_rises !== 32) begin
            errors++;
            $display("FAIL first_done: DONE pulses=%0d SCLK rises=%0d required 1 and 32",
                     done_cnt, sclk_rises);
        end
        repeat (30) tick();
        checks++;
        if (frames.size() !== 1) begin
            errors++;
            $display("FAIL first_no_repeat: frames=%0d required 1", frames.size());
        end
    endtask

    task automatic test_change_idle();
        clear_mon();
        VOL = 16'h2020;
        wait_quiet();
        repeat (30) tick();
        checks++;
        if (frames.size() !== 1) begin
            errors++;
            $display("FAIL idle_change_count: frames=%0d required 1", frames.size());
        end else begin
            checks++;
            if (frames[0] !== exp_frame(16'h2020)) begin
                errors++;
                $display("FAIL idle_change_data: got %h required %h", frames[0], exp_frame(16'h2020));
            end
        end
    endtask

    task automatic test_busy_changes();
        clear_mon();
        done_cnt = 0;
        min_gap  = 1000;
        VOL = 16'h1010;
        repeat (20) tick();
        VOL = 16'h2020;
        repeat (20) tick();
        VOL = 16'h3030;
        wait_quiet();
        checks++;
        if (frames.size() !== 2) begin
            errors++;
            $display("FAIL busy_count: frames=%0d required 2", frames.size());
        end else begin
            checks++;
            if (frames[0] !== exp_frame(16'h1010) || frames[1] !== exp_frame(16'h3030)) begin
                errors++;
                $display("FAIL busy_data: got %h %h required %h %h", frames[0], frames[1],
                         exp_frame(16'h1010), exp_frame(16'h3030));
            end
        end
        checks++;
        if (min_gap < GAP || done_cnt !== 2) begin
            errors++;
            $display("FAIL busy_gap: gap=%0d done=%0d required gap>=%0d done=2", min_gap, done_cnt, GAP);
        end
    endtask

    task automatic test_dreq_stall_force();
        int bad = 0;
        int fell = 0;
        clear_mon();
        DREQ = 1'b0;
        VOL  = 16'h4040;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (XCS !== 1'b1 || BUSY !== 1'b1 || ERR !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles required 0 (XCS=1 BUSY=1 ERR=0)", bad);
        end
        DREQ = 1'b1;
        #1;
        checks++;
        if (XCS !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: XCS=%b required 1 before DREQ is sampled", XCS);
        end
        for (int i = 0; i < 2 && !fell; i++) begin
            tick();
            if (XCS === 1'b0) fell = 1;
        end
        checks++;
        if (!fell) begin
            errors++;
            $display("FAIL stall_release: XCS=%b required 0 within 2 cycles of DREQ", XCS);
        end
        wait_quiet();
        pulse_force();
        wait_quiet();
        pulse_force();
        repeat (5) tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL force_busy: BUSY=%b required 1", BUSY);
        end
        pulse_force();
        wait_quiet();
        checks++;
        if (frames.size() !== 3) begin
            errors++;
            $display("FAIL force_count: frames=%0d required 3", frames.size());
        end else begin
            checks++;
            if (frames[0] !== exp_frame(16'h4040) || frames[1] !== exp_frame(16'h4040) ||
                frames[2] !== exp_frame(16'h4040)) begin
                errors++;
                $display("FAIL force_data: got %h %h %h required %h", frames[0], frames[1],
                         frames[2], exp_frame(16'h4040));
            end
        end
    endtask

    task automatic test_reset_mid();
        int reached = 0;
        clear_mon();
        VOL = 16'h5050;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge CLK);
            if (mon_bits >= 10) reached = 1;
        end
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if (!reached || XCS !== 1'b1 || SCLK !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: reached=%0d XCS=%b SCLK=%b BUSY=%b required 1 1 0 0",
                     reached, XCS, SCLK, BUSY);
        end
        repeat (3) tick();
        RST_N = 1'b1;
        wait_quiet();
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        wait_quiet();
        checks++;
        if (frames.size() !== 2) begin
            errors++;
            $display("FAIL rst_resend_count: frames=%0d required 2", frames.size());
        end else begin
            checks++;
            if (frames[0] !== exp_frame(16'h5050) || frames[1] !== exp_frame(16'h5050) ||
                bitsq[0] !== 32) begin
                errors++;
                $display("FAIL rst_resend_data: got %h %h bits=%0d required %h and 32",
                         frames[0], frames[1], bitsq[0], exp_frame(16'h5050));
            end
        end
    endtask

    task automatic test_random(inout logic [15:0] model_sent);
        for (int it = 0; it < 24; it++) begin
            logic [15:0] v;
            int          frc;
            int          expn;
            clear_mon();
            v   = ($urandom_range(0, 2) == 0) ? model_sent : rand_vol();
            frc = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) DREQ = 1'b0;
            VOL = v;
            if (frc) pulse_force();
            repeat ($urandom_range(0, 20)) tick();
            DREQ = 1'b1;
            wait_quiet();
            expn = (v != model_sent || frc) ? 1 : 0;
            checks++;
            if (frames.size() !== expn) begin
                errors++;
                $display("FAIL rand_count[%0d]: frames=%0d required %0d (vol=%h force=%0d)",
                         it, frames.size(), expn, v, frc);
            end else if (expn == 1) begin
                checks++;
                if (frames[0] !== exp_frame(v) || lowq[0] !== 65 * DIV) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h low=%0d required %h low=%0d",
                             it, frames[0], lowq[0], exp_frame(v), 65 * DIV);
                end
            end
            if (expn == 1) model_sent = v;
        end
    endtask

`ifdef SCI_DREQ_TIMEOUT_EN
    task automatic test_timeout(input logic [15:0] model_sent);
        logic [15:0] v;
        int          bad = 0;
        int          done0, sr0;
        v = (model_sent == 16'h6060) ? 16'h7070 : 16'h6060;
        clear_mon();
        done0 = done_cnt;
        sr0   = sclk_rises;
        DREQ  = 1'b0;
        VOL   = v;
        tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start: BUSY=%b required 1", BUSY);
        end
        for (int i = 0; i < 99; i++) begin
            tick();
            if (ERR !== 1'b0 || BUSY !== 1'b1 || XCS !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tmo_early: %0d bad cycles required 0", bad);
        end
        tick();
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flag: ERR=%b BUSY=%b required 1 0", ERR, BUSY);
        end
        DREQ = 1'b1;
        repeat (30) tick();
        checks++;
        if (frames.size() !== 0 || sclk_rises !== sr0 || done_cnt !== done0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL tmo_quiet: frames=%0d sclk=%0d done=%0d BUSY=%b required 0 %0d %0d 0",
                     frames.size(), sclk_rises, done_cnt, BUSY, sr0, done0);
        end
        pulse_force();
        wait_quiet();
        checks++;
        if (frames.size() !== 1 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL tmo_retry: frames=%0d ERR=%b required 1 1", frames.size(), ERR);
        end else begin
            checks++;
            if (frames[0] !== exp_frame(v)) begin
                errors++;
                $display("FAIL tmo_retry_data: got %h required %h", frames[0], exp_frame(v));
            end
        end
    endtask
`endif

    initial begin
        logic [15:0] sent;
        test_reset();
        test_first_frame();
        test_change_idle();
        test_busy_changes();
        test_dreq_stall_force();
        test_reset_mid();
        sent = 16'h5050;
        test_random(sent);
`ifdef SCI_DREQ_TIMEOUT_EN
        test_timeout(sent);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
